// File: rtl/usb_utmi_pkg.sv
// Shared UTMI types and constants for the USB full-speed receive path.
package usb_utmi_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'd0,
    LS_DJ  = 2'd1,
    LS_DK  = 2'd2,
    LS_SE1 = 2'd3
  } utmi_line_state_t;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP,
    ABORT
  } usb_rx_state_t;

  // Six consecutive ones force a stuffed zero on the wire.
  localparam int unsigned USB_STUFF_LEN = 6;

endpackage

// File: rtl/usb_rx_dpll.sv
// Bit-clock recovery by oversampling: phase counter re-aligned on every
// line_state change, mid-bit sample strobe and NRZI decode of J/K samples.
module usb_rx_dpll
  import usb_utmi_pkg::*;
#(
  parameter int CLK_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  utmi_line_state_t line_state,
  output logic             strobe,
  output utmi_line_state_t sym,
  output logic             nrzi_bit
);

  localparam int PW = $clog2(CLK_PER_BIT);
  localparam logic [PW-1:0] PH_MID  = PW'(CLK_PER_BIT / 2);
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_PER_BIT - 1);

  logic [PW-1:0]    phase_q, phase_d, phase_now;
  utmi_line_state_t last_ls_q, last_ls_d;
  utmi_line_state_t prev_sym_q, prev_sym_d;

  always_comb begin
    // The cycle in which the line changes is phase 0, so the strobe lands mid-bit.
    phase_now  = (line_state != last_ls_q) ? '0 : phase_q;
    phase_d    = (phase_now == PH_LAST) ? '0 : phase_now + PW'(1);
    last_ls_d  = line_state;
    strobe     = (phase_now == PH_MID);
    sym        = line_state;
    nrzi_bit   = (line_state == prev_sym_q);
    prev_sym_d = prev_sym_q;
    if (strobe) begin
      case (line_state)
        LS_DJ, LS_DK: prev_sym_d = line_state;
        LS_SE0:       prev_sym_d = LS_DJ;
        default:      prev_sym_d = prev_sym_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      last_ls_q  <= LS_DJ;
      prev_sym_q <= LS_DJ;
    end else begin
      phase_q    <= phase_d;
      last_ls_q  <= last_ls_d;
      prev_sym_q <= prev_sym_d;
    end
  end

endmodule

// File: rtl/usb_utm_rx.sv
// UTM full-speed receiver: SYNC detect, bit unstuffing, LSB-first byte
// assembly, EOP detection and abort recovery, driving the UTMI rx signals.
module usb_utm_rx
  import usb_utmi_pkg::*;
#(
  parameter int CLK_PER_BIT    = 4,
  parameter int SYNC_MIN_ZEROS = 3,
  parameter int IDLE_J_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] line_state,
  input  logic       tx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_error
);

  localparam int ZW = $clog2(SYNC_MIN_ZEROS + 1);
  localparam int JW = $clog2(IDLE_J_BITS + 1);
  localparam logic [ZW-1:0] ZERO_MIN = ZW'(SYNC_MIN_ZEROS);
  localparam logic [JW-1:0] J_LAST   = JW'(IDLE_J_BITS - 1);
  localparam logic [2:0]    STUFF    = 3'(USB_STUFF_LEN);

  utmi_line_state_t ls_in;
  logic             strobe;
  utmi_line_state_t sym;
  logic             nrzi_bit;

  usb_rx_state_t state_q, state_d;
  logic [ZW-1:0] zero_cnt_q, zero_cnt_d;
  logic [2:0]    ones_cnt_q, ones_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [JW-1:0] j_cnt_q, j_cnt_d;
  logic          last_se0_q, last_se0_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_active_q, rx_active_d;
  logic          rx_error_q, rx_error_d;

  assign ls_in = utmi_line_state_t'(line_state);

  usb_rx_dpll #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_dpll (
    .clk       (clk),
    .rst       (rst),
    .line_state(ls_in),
    .strobe    (strobe),
    .sym       (sym),
    .nrzi_bit  (nrzi_bit)
  );

  always_comb begin
    state_d     = state_q;
    zero_cnt_d  = zero_cnt_q;
    ones_cnt_d  = ones_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    j_cnt_d     = j_cnt_q;
    last_se0_d  = last_se0_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_error_d  = 1'b0;

    if (strobe) begin
      case (state_q)
        IDLE: begin
          if (sym == LS_DK) begin
            state_d    = SYNC;
            zero_cnt_d = ZW'(1);
          end
        end

        SYNC: begin
          if ((sym == LS_DJ || sym == LS_DK) && !nrzi_bit) begin
            if (zero_cnt_q != ZERO_MIN) zero_cnt_d = zero_cnt_q + ZW'(1);
          end else if (sym == LS_DK && zero_cnt_q >= ZERO_MIN) begin
            state_d    = DATA;
            ones_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end

        DATA: begin
          if (sym == LS_SE1 || (ones_cnt_q == STUFF && nrzi_bit && sym != LS_SE0)) begin
            state_d    = ABORT;
            rx_error_d = 1'b1;
            j_cnt_d    = '0;
            last_se0_d = 1'b0;
          end else if (sym == LS_SE0) begin
            state_d = EOP;
          end else if (ones_cnt_q == STUFF) begin
            ones_cnt_d = '0;
          end else begin
            shreg_d    = {nrzi_bit, shreg_q[7:1]};
            ones_cnt_d = nrzi_bit ? ones_cnt_q + 3'd1 : 3'd0;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = {nrzi_bit, shreg_q[7:1]};
              rx_valid_d = 1'b1;
            end
          end
        end

        EOP: begin
          if (sym == LS_DJ) begin
            state_d = IDLE;
          end else if (sym != LS_SE0) begin
            state_d    = ABORT;
            rx_error_d = 1'b1;
            j_cnt_d    = '0;
            last_se0_d = 1'b0;
          end
        end

        ABORT: begin
          // Leave on a clean EOP (SE0 then J) or after a long enough J idle.
          if (sym == LS_DJ) begin
            if (last_se0_q || j_cnt_q == J_LAST) state_d = IDLE;
            else j_cnt_d = j_cnt_q + JW'(1);
            last_se0_d = 1'b0;
          end else begin
            j_cnt_d    = '0;
            last_se0_d = (sym == LS_SE0);
          end
        end

        default: state_d = IDLE;
      endcase
    end

    if (tx_active) begin
      state_d    = IDLE;
      rx_valid_d = 1'b0;
      rx_error_d = 1'b0;
    end

    rx_active_d = (state_d == DATA) || (state_d == EOP) || (state_d == ABORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      zero_cnt_q  <= '0;
      ones_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      j_cnt_q     <= '0;
      last_se0_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_active_q <= 1'b0;
      rx_error_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      zero_cnt_q  <= zero_cnt_d;
      ones_cnt_q  <= ones_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      j_cnt_q     <= j_cnt_d;
      last_se0_q  <= last_se0_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_active_q <= rx_active_d;
      rx_error_q  <= rx_error_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_active = rx_active_q;
  assign rx_error  = rx_error_q;

endmodule

// File: tb/tb_usb_utm_rx.sv
// Scoreboard bench for usb_utm_rx: packets are built as symbol lists with
// expected bytes/errors/rx_active edges queued, and a monitor checks them.
module tb_usb_utm_rx;

  localparam int CPB    = 4;
  localparam int IDLE_J = 8;
  localparam logic [1:0] LS_SE0 = 2'd0;
  localparam logic [1:0] LS_J   = 2'd1;
  localparam logic [1:0] LS_K   = 2'd2;
  localparam logic [1:0] LS_SE1 = 2'd3;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [1:0] line_state;
  logic       tx_active;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_error;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  logic  rst_sampled = 1'b0;
  string test_name = "reset";

  exp_t       exp_q[$];
  int         rise_q[$];
  int         fall_q[$];
  logic [1:0] sym_q[$];
  int         mark_rise, mark_fall, mark_tx, mark_rst;
  logic [1:0] level;
  int         ones;

  usb_utm_rx #(
    .CLK_PER_BIT(CPB),
    .SYNC_MIN_ZEROS(3),
    .IDLE_J_BITS(IDLE_J)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .line_state(line_state),
    .tx_active (tx_active),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_active (rx_active),
    .rx_error  (rx_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      rst_sampled = rst;
    end
  end

  // Monitor: everything the DUT presents is matched against the queues.
  initial begin
    exp_t e;
    int   r;
    logic prev_active;
    prev_active = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_sampled) begin
        checks++;
        if (rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_active !== 1'b0 || rx_error !== 1'b0) begin
          errors++;
          $display("FAIL %s reset_outputs got data=%02h v=%b a=%b e=%b want all 0",
                   test_name, rx_data, rx_valid, rx_active, rx_error);
        end
      end
      if (rx_valid === 1'b1 || rx_error === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected_output got v=%b e=%b data=%02h want nothing",
                   test_name, rx_valid, rx_error, rx_data);
        end else begin
          e = exp_q.pop_front();
          if (rx_valid && rx_error) begin
            errors++;
            $display("FAIL %s valid_and_error got both high want one", test_name);
          end else if (rx_error && !e.is_err) begin
            errors++;
            $display("FAIL %s rx_error got error want byte %02h", test_name, e.data);
          end else if (rx_valid && e.is_err) begin
            errors++;
            $display("FAIL %s rx_valid got byte %02h want error", test_name, rx_data);
          end else if (rx_valid && rx_data !== e.data) begin
            errors++;
            $display("FAIL %s rx_data got %02h want %02h", test_name, rx_data, e.data);
          end else if (rx_valid && !rx_active) begin
            errors++;
            $display("FAIL %s valid_active got rx_active=0 want 1", test_name);
          end else if (rx_valid) begin
            $display("tb %s: byte %02h at cycle %0d", test_name, rx_data, cyc);
          end else begin
            $display("tb %s: rx_error at cycle %0d", test_name, cyc);
          end
        end
      end
      if (rx_active === 1'b1 && !prev_active) begin
        checks++;
        if (rise_q.size() == 0) begin
          errors++;
          $display("FAIL %s active_rise got rise at %0d want none", test_name, cyc);
        end else begin
          r = rise_q.pop_front();
          if (r >= 0 && r != cyc) begin
            errors++;
            $display("FAIL %s active_rise got cycle %0d want %0d", test_name, cyc, r);
          end else $display("tb %s: rx_active rise at cycle %0d", test_name, cyc);
        end
      end
      if (rx_active !== 1'b1 && prev_active) begin
        checks++;
        if (fall_q.size() == 0) begin
          errors++;
          $display("FAIL %s active_fall got fall at %0d want none", test_name, cyc);
        end else begin
          r = fall_q.pop_front();
          if (r >= 0 && r != cyc) begin
            errors++;
            $display("FAIL %s active_fall got cycle %0d want %0d", test_name, cyc, r);
          end else $display("tb %s: rx_active fall at cycle %0d", test_name, cyc);
        end
      end
      prev_active = (rx_active === 1'b1);
    end
  end

  task automatic new_pkt(input string name);
    test_name = name;
    sym_q.delete();
    mark_rise = -1;
    mark_fall = -1;
    mark_tx   = -1;
    mark_rst  = -1;
    level     = LS_J;
    ones      = 0;
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) sym_q.push_back(LS_J);
    level = LS_J;
  endtask

  task automatic add_sync();
    sym_q.push_back(LS_K); sym_q.push_back(LS_J);
    sym_q.push_back(LS_K); sym_q.push_back(LS_J);
    sym_q.push_back(LS_K); sym_q.push_back(LS_J);
    sym_q.push_back(LS_K);
    mark_rise = sym_q.size();
    sym_q.push_back(LS_K);
    level = LS_K;
    ones  = 0;
  endtask

  task automatic add_bit(input logic b);
    if (!b) begin
      level = (level == LS_K) ? LS_J : LS_K;
      ones  = 0;
    end else ones++;
    sym_q.push_back(level);
    if (ones == 6) begin
      level = (level == LS_K) ? LS_J : LS_K;
      ones  = 0;
      sym_q.push_back(level);
    end
  endtask

  task automatic add_byte(input logic [7:0] b, input bit expect_it);
    for (int i = 0; i < 8; i++) add_bit(b[i]);
    if (expect_it) exp_q.push_back('{is_err: 1'b0, data: b});
  endtask

  task automatic add_eop(input bit mark);
    sym_q.push_back(LS_SE0);
    sym_q.push_back(LS_SE0);
    if (mark) mark_fall = sym_q.size();
    add_idle(5);
  endtask

  task automatic add_j_recovery();
    mark_fall = sym_q.size() + IDLE_J - 1;
    add_idle(IDLE_J + 4);
  endtask

  task automatic push_err();
    exp_q.push_back('{is_err: 1'b1, data: 8'h00});
  endtask

  // Edges may be displaced; displacement only ever grows so no bit loses its strobe.
  task automatic drive_pkt(input bit jitter);
    int cur, nd, edge_k, dur, start;
    cur = 0;
    edge_k = 0;
    for (int i = 0; i < sym_q.size(); i++) begin
      nd = cur;
      if (jitter && i + 1 < sym_q.size() && sym_q[i+1] != sym_q[i]) begin
        nd = (edge_k < 6) ? -1 : 1;
        edge_k++;
      end
      dur   = CPB + nd - cur;
      cur   = nd;
      start = cyc;
      if (i == mark_rise) rise_q.push_back(jitter ? -1 : start + CPB/2 + 1);
      if (i == mark_fall) fall_q.push_back(jitter ? -1 : start + CPB/2 + 1);
      line_state = sym_q[i];
      if (i == mark_tx || i == mark_rst) begin
        fall_q.push_back(start + 1);
        if (i == mark_tx) tx_active = 1'b1;
        else rst = 1'b1;
        @(negedge clk);
        tx_active = 1'b0;
        rst = 1'b0;
        dur--;
      end
      repeat (dur) @(negedge clk);
    end
  endtask

  task automatic chk(input string what, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s %s got %0d want %0d", test_name, what, got, want);
    end
  endtask

  task automatic finish_test();
    repeat (8) @(negedge clk);
    chk("expected_left", exp_q.size(), 0);
    chk("rise_left", rise_q.size(), 0);
    chk("fall_left", fall_q.size(), 0);
    chk("active_at_end", int'(rx_active), 0);
  endtask

  initial begin
    rst = 1'b1;
    tx_active = 1'b0;
    line_state = LS_J;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    new_pkt("basic_a5");
    add_idle(4); add_sync(); add_byte(8'hA5, 1); add_eop(1);
    drive_pkt(0); finish_test();

    new_pkt("stuffed_ff");
    add_idle(4); add_sync(); add_byte(8'hFF, 1); add_byte(8'hFF, 1); add_eop(1);
    drive_pkt(0); finish_test();

    new_pkt("stuff_error");
    add_idle(4); add_sync();
    for (int i = 0; i < 7; i++) sym_q.push_back(LS_K);
    push_err(); add_j_recovery();
    drive_pkt(0); finish_test();

    new_pkt("jitter_3c");
    add_idle(4); add_sync(); add_byte(8'h3C, 1); add_eop(1);
    drive_pkt(1); finish_test();

    new_pkt("tx_active");
    add_idle(4); add_sync(); add_byte(8'h7E, 1);
    mark_tx = sym_q.size() + 3;
    add_byte(8'h00, 0); add_eop(0);
    drive_pkt(0);
    new_pkt("after_tx");
    add_idle(4); add_sync(); add_byte(8'h81, 1); add_eop(1);
    drive_pkt(0); finish_test();

    new_pkt("mid_reset");
    add_idle(4); add_sync(); add_byte(8'hC3, 1);
    mark_rst = sym_q.size() + 2;
    add_byte(8'h00, 0); add_eop(0);
    drive_pkt(0);
    new_pkt("after_reset");
    add_idle(4); add_sync(); add_byte(8'h5A, 1); add_eop(1);
    drive_pkt(0); finish_test();

    new_pkt("eop_k_abort");
    add_idle(4); add_sync(); add_byte(8'h55, 1);
    sym_q.push_back(LS_SE0); sym_q.push_back(LS_K); push_err();
    sym_q.push_back(LS_SE0);
    mark_fall = sym_q.size();
    add_idle(5);
    drive_pkt(0); finish_test();

    new_pkt("se1_abort");
    add_idle(4); add_sync(); add_byte(8'h0F, 1);
    sym_q.push_back(LS_SE1); push_err(); add_j_recovery();
    drive_pkt(0); finish_test();

    new_pkt("partial_byte");
    add_idle(4); add_sync(); add_byte(8'h96, 1);
    add_bit(1'b1); add_bit(1'b0); add_bit(1'b1); add_eop(1);
    drive_pkt(0); finish_test();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
